// File: rtl/count_step_decoder.sv
// Watches a counter's count bus and decodes each qualified sample as an up step,
// a down step, a hold or a jump. Events come out as registered pulses with saturating counts.
module count_step_decoder #(
    parameter int WIDTH  = 4,
    parameter int STAT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              valid_in,
    input  logic              stat_clr,
    output logic              step_up,
    output logic              step_down,
    output logic              hold,
    output logic              jump,
    output logic              wrap,
    output logic              turn,
    output logic              dir,
    output logic [WIDTH-1:0]  jump_val,
    output logic [STAT_W-1:0] up_cnt,
    output logic [STAT_W-1:0] down_cnt,
    output logic [STAT_W-1:0] jump_cnt
);

    typedef enum logic [1:0] {EMPTY, PRIMED, TRACK} state_t;

    localparam logic [WIDTH-1:0]  W_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0]  W_ONES = '1;
    localparam logic [WIDTH-1:0]  W_ZERO = '0;
    localparam logic [STAT_W-1:0] S_ONE  = STAT_W'(1);
    localparam logic [STAT_W-1:0] S_MAX  = '1;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] diff;
    logic             classify;
    logic             is_up, is_dn, is_hold, is_jump;

    assign diff     = count_in - prev;
    assign classify = valid_in && (state != EMPTY);
    assign is_up    = classify && (diff == W_ONE);
    assign is_dn    = classify && (diff == W_ONES);
    assign is_hold  = classify && (diff == W_ZERO);
    assign is_jump  = classify && !is_up && !is_dn && !is_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            prev      <= '0;
            step_up   <= 1'b0;
            step_down <= 1'b0;
            hold      <= 1'b0;
            jump      <= 1'b0;
            wrap      <= 1'b0;
            turn      <= 1'b0;
            dir       <= 1'b1;
            jump_val  <= '0;
            up_cnt    <= '0;
            down_cnt  <= '0;
            jump_cnt  <= '0;
        end else begin
            step_up   <= is_up;
            step_down <= is_dn;
            hold      <= is_hold;
            jump      <= is_jump;
            wrap      <= (is_up && prev == W_ONES) || (is_dn && prev == W_ZERO);
            // only a step seen in TRACK can turn; the first step after PRIMED just loads dir
            turn      <= (is_up || is_dn) && (state == TRACK) && (is_up != dir);

            if (valid_in) begin
                prev <= count_in;
                if (state == EMPTY) begin
                    state <= PRIMED;
                end else if (is_up || is_dn) begin
                    state <= TRACK;
                    dir   <= is_up;
                end else if (is_jump) begin
                    state    <= PRIMED;
                    jump_val <= count_in;
                end
            end

            if (stat_clr) begin
                up_cnt   <= '0;
                down_cnt <= '0;
                jump_cnt <= '0;
            end else begin
                if (is_up && up_cnt != S_MAX)     up_cnt   <= up_cnt + S_ONE;
                if (is_dn && down_cnt != S_MAX)   down_cnt <= down_cnt + S_ONE;
                if (is_jump && jump_cnt != S_MAX) jump_cnt <= jump_cnt + S_ONE;
            end
        end
    end

endmodule
